// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl
//   Controller for the hour/min/sec time-of-day counter. Derives the seconds
//   tick from clk, runs the button-driven set-mode sequence
//   RUN -> SET_HOUR -> SET_MIN -> RUN, and issues one-cycle increment/clear
//   commands plus a blink phase for the display.
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   btn_mode  in   mode button (debounced, synchronous level)
//   btn_up    in   increment button (debounced, synchronous level)
//   run_en    out  counter enable, high only in RUN
//   sec_tick  out  one-cycle seconds pulse
//   inc_hour  out  one-cycle hour-increment command
//   inc_min   out  one-cycle minute-increment command
//   clr_sec   out  one-cycle seconds-clear command (on return to RUN)
//   mode      out  0=RUN, 1=SET_HOUR, 2=SET_MIN
//   blink     out  blink phase for the field being set, 0 in RUN
//
// Build option
//   CLOCK_MODE_CTRL_SET_TIMEOUT_EN : when defined, SET modes fall back to RUN
//   after TIMEOUT_CYC cycles without button activity.
module clock_mode_ctrl #(
    parameter int unsigned CLK_DIV     = 50000000,
    parameter int unsigned REPEAT_DLY  = 25000000,
    parameter int unsigned REPEAT_PER  = 5000000,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       run_en,
    output logic       sec_tick,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blink
);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("clock_mode_ctrl: CLK_DIV must be >= 4");
    end
    if (REPEAT_DLY < 2) begin : g_bad_repeat_dly
        $error("clock_mode_ctrl: REPEAT_DLY must be >= 2");
    end
    if (REPEAT_PER < 2) begin : g_bad_repeat_per
        $error("clock_mode_ctrl: REPEAT_PER must be >= 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("clock_mode_ctrl: TIMEOUT_CYC must be >= 1");
    end

    localparam int unsigned PW         = $clog2(CLK_DIV);
    localparam int unsigned REP_MAX    = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW         = $clog2(REP_MAX + 1);
    localparam int unsigned BLINK_HALF = CLK_DIV / 2;
    localparam int unsigned BW         = $clog2(BLINK_HALF);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [RW-1:0] REP_DLY_C  = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] REP_PER_C  = RW'(REPEAT_PER);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    mode_e         mode_q,          mode_d;
    logic [PW-1:0] presc_q,         presc_d;
    logic [RW-1:0] rep_q,           rep_d;
    logic          rep_phase_q,     rep_phase_d;
    logic          btn_mode_prev_q, btn_mode_prev_d;
    logic          btn_up_prev_q,   btn_up_prev_d;
    logic          inc_hour_q,      inc_hour_d;
    logic          inc_min_q,       inc_min_d;
    logic          clr_sec_q,       clr_sec_d;
    logic          blink_q,         blink_d;
    logic [BW-1:0] blink_cnt_q,     blink_cnt_d;

`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
    localparam int unsigned   TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYC);
    logic [TW-1:0] idle_q, idle_d;
    logic [TW-1:0] idle_inc;
`endif

    logic          mode_edge;
    logic          up_edge;
    logic          in_set;
    logic          rep_fire;
    logic [RW-1:0] rep_inc;
    logic          timeout;
    logic          mode_chg;

    always_comb begin
        mode_edge = btn_mode & ~btn_mode_prev_q;
        up_edge   = btn_up & ~btn_up_prev_q;
        in_set    = (mode_q != MODE_RUN);

        // Auto-repeat: phase 0 waits REPEAT_DLY held cycles, phase 1 then
        // fires every REPEAT_PER cycles. A mode edge suppresses counting.
        rep_d       = '0;
        rep_phase_d = 1'b0;
        rep_fire    = 1'b0;
        rep_inc     = rep_q + RW'(1);
        if (in_set && btn_up && !mode_edge) begin
            rep_d       = rep_inc;
            rep_phase_d = rep_phase_q;
            if (!rep_phase_q && (rep_inc == REP_DLY_C)) begin
                rep_fire    = 1'b1;
                rep_d       = '0;
                rep_phase_d = 1'b1;
            end else if (rep_phase_q && (rep_inc == REP_PER_C)) begin
                rep_fire = 1'b1;
                rep_d    = '0;
            end
        end

        timeout = 1'b0;
`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
        idle_inc = idle_q + TW'(1);
        idle_d   = '0;
        if (in_set && !(mode_edge || up_edge || rep_fire)) begin
            if (idle_inc == TIMEOUT_C) begin
                timeout = 1'b1;
            end else begin
                idle_d = idle_inc;
            end
        end
`endif

        // A mode edge takes priority over a simultaneous timeout.
        mode_d = mode_q;
        if (mode_edge) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_d = MODE_SET_MIN;
                default:       mode_d = MODE_RUN;
            endcase
        end else if (timeout) begin
            mode_d = MODE_RUN;
        end
        mode_chg = (mode_d != mode_q);

        if (mode_chg) begin
            rep_d       = '0;
            rep_phase_d = 1'b0;
        end

        inc_hour_d = (up_edge || rep_fire) && (mode_q == MODE_SET_HOUR) && !mode_chg;
        inc_min_d  = (up_edge || rep_fire) && (mode_q == MODE_SET_MIN) && !mode_chg;
        clr_sec_d  = in_set && (mode_d == MODE_RUN);

        // Prescaler only advances while staying in RUN; entering RUN starts at 0.
        presc_d = '0;
        if ((mode_q == MODE_RUN) && (mode_d == MODE_RUN)) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end

        // Blink restarts high on every entry into a SET mode.
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        if (mode_d != MODE_RUN) begin
            if (mode_chg) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end

        btn_mode_prev_d = btn_mode;
        btn_up_prev_d   = btn_up;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q          <= MODE_RUN;
            presc_q         <= '0;
            rep_q           <= '0;
            rep_phase_q     <= 1'b0;
            btn_mode_prev_q <= 1'b0;
            btn_up_prev_q   <= 1'b0;
            inc_hour_q      <= 1'b0;
            inc_min_q       <= 1'b0;
            clr_sec_q       <= 1'b0;
            blink_q         <= 1'b0;
            blink_cnt_q     <= '0;
`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
            idle_q          <= '0;
`endif
        end else begin
            mode_q          <= mode_d;
            presc_q         <= presc_d;
            rep_q           <= rep_d;
            rep_phase_q     <= rep_phase_d;
            btn_mode_prev_q <= btn_mode_prev_d;
            btn_up_prev_q   <= btn_up_prev_d;
            inc_hour_q      <= inc_hour_d;
            inc_min_q       <= inc_min_d;
            clr_sec_q       <= clr_sec_d;
            blink_q         <= blink_d;
            blink_cnt_q     <= blink_cnt_d;
`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
            idle_q          <= idle_d;
`endif
        end
    end

    assign run_en   = (mode_q == MODE_RUN);
    assign sec_tick = (mode_q == MODE_RUN) && (presc_q == PRESC_LAST);
    assign inc_hour = inc_hour_q;
    assign inc_min  = inc_min_q;
    assign clr_sec  = clr_sec_q;
    assign mode     = mode_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;

    localparam int CLK_DIV     = 10;
    localparam int REPEAT_DLY  = 8;
    localparam int REPEAT_PER  = 3;
    localparam int TIMEOUT_CYC = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       run_en, sec_tick, inc_hour, inc_min, clr_sec, blink;
    logic [1:0] mode;

    clock_mode_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_PER  (REPEAT_PER),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .run_en   (run_en),
        .sec_tick (sec_tick),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .clr_sec  (clr_sec),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       run_en;
        logic       sec_tick;
        logic       inc_hour;
        logic       inc_min;
        logic       clr_sec;
        logic [1:0] mode;
        logic       blink;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   n_tick = 0;
    int   n_hour = 0;
    int   n_min  = 0;

    // Reference model: ages since mode entry, hold length since press.
    int   m_mode    = 0;
    int   m_held    = 0;
    int   m_run_age = 0;
    int   m_set_age = 0;
    bit   m_mprev   = 1'b0;
    bit   m_uprev   = 1'b0;
`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
    int   m_idle    = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic out_t model_step(input bit bm, input bit bu, input bit rn);
        out_t e;
        bit   medge, uedge, in_set, fire, timeout, inc;
        int   held_new, nm;
        e = '0;
        if (!rn) begin
            m_mode = 0; m_held = 0; m_run_age = 0; m_set_age = 0;
            m_mprev = 1'b0; m_uprev = 1'b0;
`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
            m_idle = 0;
`endif
            e.run_en = 1'b1;
            return e;
        end
        medge    = bm && !m_mprev;
        uedge    = bu && !m_uprev;
        in_set   = (m_mode != 0);
        held_new = (in_set && bu && !medge) ? m_held + 1 : 0;
        fire     = (held_new >= REPEAT_DLY) && (((held_new - REPEAT_DLY) % REPEAT_PER) == 0);
        timeout  = 1'b0;
`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
        if (in_set) begin
            if (medge || uedge || fire) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) begin
                    timeout = 1'b1;
                    m_idle  = 0;
                end
            end
        end else begin
            m_idle = 0;
        end
`endif
        if (medge)        nm = (m_mode == 0) ? 1 : (m_mode == 1) ? 2 : 0;
        else if (timeout) nm = 0;
        else              nm = m_mode;
        inc        = (uedge || fire) && in_set && (nm == m_mode);
        e.inc_hour = inc && (m_mode == 1);
        e.inc_min  = inc && (m_mode == 2);
        e.clr_sec  = in_set && (nm == 0);
        if (nm != m_mode) held_new = 0;
        if (nm == 0) m_run_age = (m_mode == 0) ? m_run_age + 1 : 0;
        else         m_set_age = (nm == m_mode) ? m_set_age + 1 : 0;
        m_mode  = nm;
        m_held  = held_new;
        m_mprev = bm;
        m_uprev = bu;
        e.run_en   = (nm == 0);
        e.mode     = 2'(nm);
        e.sec_tick = (nm == 0) && ((m_run_age % CLK_DIV) == CLK_DIV - 1);
        e.blink    = (nm != 0) && (((m_set_age / (CLK_DIV / 2)) % 2) == 0);
        return e;
    endfunction

    // One cycle: compare the outputs of the previous posedge against the
    // queued expectation, then drive inputs for the next posedge.
    task automatic step(input bit bm, input bit bu, input bit rn);
        out_t e, o;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = {run_en, sec_tick, inc_hour, inc_min, clr_sec, mode, blink};
            check($sformatf("outputs@%0d", cyc), 32'(o), 32'(e));
            n_tick += int'(sec_tick);
            n_hour += int'(inc_hour);
            n_min  += int'(inc_min);
        end
        btn_mode = bm;
        btn_up   = bu;
        rst_n    = rn;
        exp_q.push_back(model_step(bm, bu, rn));
        cyc++;
    endtask

    initial begin
        // Reset
        step(0, 0, 0);
        step(0, 0, 0);
        check("rst_mode",   32'(mode),   32'd0);
        check("rst_run_en", 32'(run_en), 32'd1);
        check("rst_blink",  32'(blink),  32'd0);
        check("rst_pulses", 32'({sec_tick, inc_hour, inc_min, clr_sec}), 32'd0);

        // Free-running RUN: ticks at cycles 9,19,29,39
        n_tick = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 1);
            check($sformatf("tick_c%0d", i), 32'(sec_tick), 32'((i % 10) == 9));
        end
        check("tick_count40", 32'(n_tick), 32'd4);

        // Mode walk
        step(1, 0, 1);
        step(0, 0, 1);
        check("walk_mode1",   32'(mode),     32'd1);
        check("walk_run_en0", 32'(run_en),   32'd0);
        check("walk_blink1",  32'(blink),    32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(1, 0, 1);
        step(0, 0, 1);
        check("walk_mode2", 32'(mode), 32'd2);
        step(1, 0, 1);
        step(0, 0, 1);
        check("walk_mode0", 32'(mode),    32'd0);
        check("walk_clr",   32'(clr_sec), 32'd1);
        for (int j = 1; j <= 9; j++) begin
            step(0, 0, 1);
            check($sformatf("exit_tick_j%0d", j), 32'(sec_tick), 32'(j == 9));
        end

        // Auto-repeat in SET_HOUR
        step(1, 0, 1);
        step(0, 0, 1);
        check("hour_entry", 32'(mode), 32'd1);
        n_hour = 0;
        n_min  = 0;
        for (int k = 0; k < 30; k++) begin
            step(0, k < 20, 1);
            if (k >= 1)
                check($sformatf("rep_hour_k%0d", k), 32'(inc_hour),
                      32'(k == 1 || k == 8 || k == 11 || k == 14 || k == 17 || k == 20));
        end
        check("rep_hour_count", 32'(n_hour), 32'd6);
        check("rep_min_count",  32'(n_min),  32'd0);

        // Simultaneous btn_mode / btn_up edges: mode wins
        step(1, 1, 1);
        step(0, 0, 1);
        check("sim_mode2", 32'(mode), 32'd2);
        check("sim_noinc", 32'({inc_hour, inc_min}), 32'd0);

        // Reset while an inc_min pulse is showing during auto-repeat
        for (int k = 0; k <= 8; k++) step(0, 1, (k == 8) ? 1'b0 : 1'b1);
        check("midrep_inc_min", 32'(inc_min), 32'd1);
        step(0, 0, 1);
        check("midrst_mode",   32'(mode),   32'd0);
        check("midrst_run_en", 32'(run_en), 32'd1);
        check("midrst_blink",  32'(blink),  32'd0);
        check("midrst_pulses", 32'({sec_tick, inc_hour, inc_min, clr_sec}), 32'd0);
        for (int j = 1; j <= 9; j++) begin
            step(0, 0, 1);
            check($sformatf("rst_tick_j%0d", j), 32'(sec_tick), 32'(j == 9));
        end

        // btn_up in RUN is ignored
        n_hour = 0;
        n_min  = 0;
        for (int k = 0; k < 15; k++) step(0, 1, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        check("run_up_noinc", 32'(n_hour + n_min), 32'd0);

        // Inactivity in SET_HOUR
        step(1, 0, 1);
`ifdef CLOCK_MODE_CTRL_SET_TIMEOUT_EN
        for (int k = 1; k <= 40; k++) begin
            step(0, 0, 1);
            check($sformatf("to_mode_k%0d", k), 32'(mode), (k < 31) ? 32'd1 : 32'd0);
            if (k == 31) check("to_clr", 32'(clr_sec), 32'd1);
        end
`else
        for (int k = 1; k <= 100; k++) begin
            step(0, 0, 1);
            if (k == 1 || k == 100) check($sformatf("noto_mode_k%0d", k), 32'(mode), 32'd1);
        end
`endif
        step(0, 0, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
